// File: rtl/mix_addchar_unit_if.sv
// Sequencer-side bundle for the MIX ADD/CHAR execution unit: start/stop strobes,
// operands and results for both instructions.
interface mix_addchar_unit_if;
    logic        add_start;
    logic [30:0] add_in1;
    logic [30:0] add_in2;
    logic        add_stop;
    logic [30:0] add_out;
    logic        add_overflow;
    logic        char_start;
    logic [29:0] char_in;
    logic        char_stop;
    logic        char_busy;
    logic [59:0] char_out;

    modport master (
        output add_start, add_in1, add_in2, char_start, char_in,
        input  add_stop, add_out, add_overflow, char_stop, char_busy, char_out
    );

    modport slave (
        input  add_start, add_in1, add_in2, char_start, char_in,
        output add_stop, add_out, add_overflow, char_stop, char_busy, char_out
    );
endinterface

// File: rtl/mix_addchar_unit.sv
// MIX ADD (sign-magnitude add, combinational value path, registered stop strobe) and
// CHAR (30-bit binary to ten character codes via one-bit-per-cycle double-dabble).
module mix_addchar_unit (
    input  logic                 clk,
    input  logic                 reset,
    mix_addchar_unit_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } char_state_t;

    // ADD value path
    logic        sign1;
    logic        sign2;
    logic [29:0] mag1;
    logic [29:0] mag2;
    logic [30:0] sum_same;
    logic        mag1_ge;
    logic [29:0] mag_diff;
    logic [30:0] add_result;
    logic        add_ovf;

    assign sign1    = bus.add_in1[30];
    assign sign2    = bus.add_in2[30];
    assign mag1     = bus.add_in1[29:0];
    assign mag2     = bus.add_in2[29:0];
    assign sum_same = {1'b0, mag1} + {1'b0, mag2};
    assign mag1_ge  = (mag1 >= mag2);
    assign mag_diff = mag1_ge ? (mag1 - mag2) : (mag2 - mag1);

    // Equal magnitudes with opposite signs take rA's sign via the mag1_ge branch.
    always_comb begin
        add_result = '0;
        add_ovf    = 1'b0;
        if (sign1 == sign2) begin
            add_result = {sign1, sum_same[29:0]};
            add_ovf    = sum_same[30];
        end else begin
            add_result = {(mag1_ge ? sign1 : sign2), mag_diff};
            add_ovf    = 1'b0;
        end
    end

    assign bus.add_out      = add_result;
    assign bus.add_overflow = add_ovf;

    // CHAR conversion state
    char_state_t state_reg;
    logic [4:0]  count_reg;
    logic [29:0] bin_reg;
    logic [39:0] bcd_reg;
    logic [39:0] bcd_adj;
    logic [39:0] bcd_next;
    logic [59:0] code_next;
    logic [59:0] char_out_reg;
    logic        char_stop_reg;
    logic        char_busy_reg;
    logic        add_stop_reg;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_digit
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                        ? (bcd_reg[gi*4 +: 4] + 4'd3)
                                        : bcd_reg[gi*4 +: 4];
            assign code_next[gi*6 +: 6] = 6'd30 + {2'b00, bcd_next[gi*4 +: 4]};
        end
    endgenerate

    assign bcd_next = {bcd_adj[38:0], bin_reg[29]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            bin_reg       <= '0;
            bcd_reg       <= '0;
            char_out_reg  <= '0;
            char_stop_reg <= 1'b0;
            char_busy_reg <= 1'b0;
            add_stop_reg  <= 1'b0;
        end else begin
            add_stop_reg <= bus.add_start;
            case (state_reg)
                IDLE: begin
                    char_stop_reg <= 1'b0;
                    if (bus.char_start) begin
                        bin_reg       <= bus.char_in;
                        bcd_reg       <= '0;
                        count_reg     <= 5'd30;
                        char_busy_reg <= 1'b1;
                        state_reg     <= CONV;
                    end
                end
                CONV: begin
                    bin_reg   <= {bin_reg[28:0], 1'b0};
                    bcd_reg   <= bcd_next;
                    count_reg <= count_reg - 5'd1;
                    // Last shift: publish the final digits straight from bcd_next.
                    if (count_reg == 5'd1) begin
                        char_out_reg  <= code_next;
                        char_stop_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    char_stop_reg <= 1'b0;
                    char_busy_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: begin
                    char_stop_reg <= 1'b0;
                    char_busy_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign bus.add_stop  = add_stop_reg;
    assign bus.char_stop = char_stop_reg;
    assign bus.char_busy = char_busy_reg;
    assign bus.char_out  = char_out_reg;

endmodule

// File: tb/tb_mix_addchar_unit.sv
// Directed bench for mix_addchar_unit: ADD sign/overflow cases, CHAR conversions,
// strobe timing, reset abort and ignored restarts.
module tb_mix_addchar_unit;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    mix_addchar_unit_if bus ();

    mix_addchar_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.add_start = 1'b1;
        bus.char_start = 1'b1;
        bus.char_in = 30'd12977;
        bus.add_in1 = '0;
        bus.add_in2 = '0;
        next_cycle();
        next_cycle();
        bus.add_start = 1'b0;
        bus.char_start = 1'b0;
        tests_run++;
        if (bus.add_stop !== 1'b0 || bus.char_stop !== 1'b0 || bus.char_busy !== 1'b0 || bus.char_out !== 60'd0) begin
            tests_failed++;
            $display("FAIL reset_state: add_stop=%b char_stop=%b char_busy=%b char_out=%h required 0 0 0 0",
                     bus.add_stop, bus.char_stop, bus.char_busy, bus.char_out);
        end
        reset = 1'b0;
        next_cycle();
        tests_run++;
        if (bus.add_stop !== 1'b0 || bus.char_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobe_discarded: add_stop=%b char_busy=%b required 0 0", bus.add_stop, bus.char_busy);
        end
    endtask

    task automatic test_add();
        logic [30:0] a   [8] = '{{1'b0, 30'd5}, {1'b0, 30'h3FFFFFFF}, {1'b1, 30'h3FFFFFFF}, {1'b0, 30'd5},
                                 {1'b1, 30'd5}, {1'b0, 30'd5}, {1'b1, 30'd0}, {1'b1, 30'd3}};
        logic [30:0] b   [8] = '{{1'b0, 30'd7}, {1'b0, 30'd1}, {1'b1, 30'd2}, {1'b1, 30'd7},
                                 {1'b0, 30'd5}, {1'b1, 30'd5}, {1'b0, 30'd0}, {1'b1, 30'd4}};
        logic [30:0] sum [8] = '{{1'b0, 30'd12}, {1'b0, 30'd0}, {1'b1, 30'd1}, {1'b1, 30'd2},
                                 {1'b1, 30'd0}, {1'b0, 30'd0}, {1'b1, 30'd0}, {1'b1, 30'd7}};
        logic        ovf [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            bus.add_start = 1'b1;
            bus.add_in1 = a[i];
            bus.add_in2 = b[i];
            next_cycle();
            bus.add_start = 1'b0;
            tests_run++;
            if (bus.add_stop !== 1'b1 || bus.add_out !== sum[i] || bus.add_overflow !== ovf[i]) begin
                tests_failed++;
                $display("FAIL add_vec%0d: stop=%b out=%h ovf=%b required stop=1 out=%h ovf=%b",
                         i, bus.add_stop, bus.add_out, bus.add_overflow, sum[i], ovf[i]);
            end
            next_cycle();
            tests_run++;
            if (bus.add_stop !== 1'b0) begin
                tests_failed++;
                $display("FAIL add_stop_single%0d: add_stop=%b required 0", i, bus.add_stop);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.add_start = 1'b1;
        bus.add_in1 = {1'b0, 30'd100};
        bus.add_in2 = {1'b0, 30'd23};
        next_cycle();
        tests_run++;
        if (bus.add_stop !== 1'b1 || bus.add_out !== {1'b0, 30'd123}) begin
            tests_failed++;
            $display("FAIL b2b_first: stop=%b out=%h required stop=1 out=%h", bus.add_stop, bus.add_out, {1'b0, 30'd123});
        end
        bus.add_in1 = {1'b1, 30'd10};
        bus.add_in2 = {1'b0, 30'd4};
        next_cycle();
        bus.add_start = 1'b0;
        tests_run++;
        if (bus.add_stop !== 1'b1 || bus.add_out !== {1'b1, 30'd6}) begin
            tests_failed++;
            $display("FAIL b2b_second: stop=%b out=%h required stop=1 out=%h", bus.add_stop, bus.add_out, {1'b1, 30'd6});
        end
        next_cycle();
        tests_run++;
        if (bus.add_stop !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: add_stop=%b required 0", bus.add_stop);
        end
    endtask

    task automatic test_char();
        logic [29:0] vin   [3] = '{30'd12977, 30'd0, 30'd1073741823};
        int          codes [3][10] = '{'{30, 30, 30, 30, 30, 31, 32, 39, 37, 37},
                                       '{30, 30, 30, 30, 30, 30, 30, 30, 30, 30},
                                       '{31, 30, 37, 33, 37, 34, 31, 38, 32, 33}};
        logic [59:0] exp_out;
        int          n;
        int          busy_bad;
        for (int v = 0; v < 3; v++) begin
            exp_out = '0;
            for (int k = 0; k < 10; k++) exp_out[(9-k)*6 +: 6] = 6'(codes[v][k]);
            bus.char_start = 1'b1;
            bus.char_in = vin[v];
            n = 0;
            busy_bad = 0;
            next_cycle();
            bus.char_start = 1'b0;
            bus.char_in = 30'h2AAAAAAA;
            n = 1;
            while (bus.char_stop !== 1'b1 && n < 40) begin
                if (bus.char_busy !== 1'b1) busy_bad++;
                next_cycle();
                n++;
            end
            tests_run++;
            if (n != 31 || busy_bad != 0 || bus.char_busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL char_timing%0d: stop after %0d cycles, busy gaps %0d, busy at stop %b required 31 0 1",
                         v, n, busy_bad, bus.char_busy);
            end
            tests_run++;
            if (bus.char_out !== exp_out) begin
                tests_failed++;
                $display("FAIL char_value%0d: char_out=%h required %h", v, bus.char_out, exp_out);
            end
            next_cycle();
            tests_run++;
            if (bus.char_stop !== 1'b0 || bus.char_busy !== 1'b0 || bus.char_out !== exp_out) begin
                tests_failed++;
                $display("FAIL char_after%0d: stop=%b busy=%b out=%h required 0 0 %h",
                         v, bus.char_stop, bus.char_busy, bus.char_out, exp_out);
            end
        end
    endtask

    task automatic test_char_reset();
        int stops;
        bus.char_start = 1'b1;
        bus.char_in = 30'd12977;
        next_cycle();
        bus.char_start = 1'b0;
        for (int i = 1; i < 10; i++) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        stops = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.char_stop === 1'b1) stops++;
            next_cycle();
        end
        tests_run++;
        if (stops != 0 || bus.char_busy !== 1'b0 || bus.char_out !== 60'd0) begin
            tests_failed++;
            $display("FAIL char_reset_abort: stops=%0d busy=%b out=%h required 0 0 0", stops, bus.char_busy, bus.char_out);
        end
    endtask

    task automatic test_char_ignore();
        logic [59:0] exp_out;
        int          stops;
        int          first_at;
        exp_out = {6'd31, 6'd30, 6'd37, 6'd33, 6'd37, 6'd34, 6'd31, 6'd38, 6'd32, 6'd33};
        bus.char_start = 1'b1;
        bus.char_in = 30'd1073741823;
        next_cycle();
        bus.char_start = 1'b0;
        stops = 0;
        first_at = 0;
        for (int n = 1; n <= 70; n++) begin
            if (bus.char_stop === 1'b1) begin
                stops++;
                if (first_at == 0) first_at = n;
            end
            bus.char_start = (n == 5 || n == 30);
            bus.char_in = 30'd12977;
            next_cycle();
        end
        bus.char_start = 1'b0;
        tests_run++;
        if (stops != 1 || first_at != 31) begin
            tests_failed++;
            $display("FAIL char_ignore_stops: stops=%0d first at %0d required 1 at 31", stops, first_at);
        end
        tests_run++;
        if (bus.char_out !== exp_out) begin
            tests_failed++;
            $display("FAIL char_ignore_value: char_out=%h required %h", bus.char_out, exp_out);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        bus.add_start = 1'b0;
        bus.add_in1 = '0;
        bus.add_in2 = '0;
        bus.char_start = 1'b0;
        bus.char_in = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_char();
        test_char_reset();
        test_char_ignore();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
